// File: rtl/bf_pkg.sv
// Shared encodings for the byte-memory responder: FSM states, host commands
// and the processor output-enable patterns.
package bf_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_LOAD = 2'b01,
    ST_RUN  = 2'b10,
    ST_DUMP = 2'b11
  } state_e;

  typedef enum logic [1:0] {
    CMD_NONE = 2'b00,
    CMD_LOAD = 2'b01,
    CMD_RUN  = 2'b10,
    CMD_DUMP = 2'b11
  } host_cmd_e;

  localparam logic [7:0] OE_READ  = 8'h00;
  localparam logic [7:0] OE_WRITE = 8'hFF;

  // Any output-enable pattern other than all-read or all-write is a bus fault.
  function automatic logic oe_malformed(input logic [7:0] oe);
    return (oe != OE_READ) && (oe != OE_WRITE);
  endfunction

endpackage

// File: rtl/bf_mem_array.sv
// Byte array with one synchronous write port and two combinational read ports
// (processor side and dump side).
module bf_mem_array #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [7:0]        i_wdata,
  input  logic [ADDR_W-1:0] i_raddr_a,
  output logic [7:0]        o_rdata_a,
  input  logic [ADDR_W-1:0] i_raddr_b,
  output logic [7:0]        o_rdata_b
);

  logic [7:0] r_mem [2**ADDR_W];

  // NOTE: the storage array has no reset so it maps onto plain RAM; its
  // contents must survive rst_n, which only abandons the transfer in flight.
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata_a = r_mem[i_raddr_a];
  assign o_rdata_b = r_mem[i_raddr_b];

endmodule

// File: rtl/bf_mem_responder.sv
// Host-controlled memory for a small processor: the host loads a program,
// lets the processor run against the memory, then dumps the whole array.
module bf_mem_responder
  import bf_pkg::*;
#(
  parameter int ADDR_W    = 8,
  parameter int LOAD_BASE = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] bus_addr,
  input  logic [7:0]        bus_wdata,
  input  logic [7:0]        bus_oe,
  output logic [7:0]        bus_rdata,
  output logic              cpu_ena,
  input  logic [1:0]        host_cmd,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [7:0]        in_data,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [7:0]        out_data,
  output logic              bus_err,
  output logic [1:0]        state_o
);

  localparam logic [ADDR_W-1:0] LOAD_PTR = ADDR_W'(LOAD_BASE);
  localparam logic [ADDR_W-1:0] TOP_ADDR = '1;

  state_e            r_state;
  state_e            w_state_nxt;
  logic [ADDR_W-1:0] r_ptr;
  logic [ADDR_W-1:0] w_ptr_nxt;
  logic              r_bus_err;
  logic              w_err_set;
  logic              w_we;
  logic [ADDR_W-1:0] w_waddr;
  logic [7:0]        w_wdata;
  logic [7:0]        w_bus_rd;
  logic [7:0]        w_dump_rd;
  host_cmd_e         w_cmd;

  assign w_cmd = host_cmd_e'(host_cmd);

  bf_mem_array #(.ADDR_W(ADDR_W)) u_mem (
    .clk       (clk),
    .i_we      (w_we),
    .i_waddr   (w_waddr),
    .i_wdata   (w_wdata),
    .i_raddr_a (bus_addr),
    .o_rdata_a (w_bus_rd),
    .i_raddr_b (r_ptr),
    .o_rdata_b (w_dump_rd)
  );

  // NOTE: every signal gets its default before the case so no path leaves a
  // value unassigned, which would otherwise infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    w_we        = 1'b0;
    w_waddr     = r_ptr;
    w_wdata     = in_data;
    w_err_set   = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        unique case (w_cmd)
          CMD_LOAD: begin
            w_state_nxt = ST_LOAD;
            w_ptr_nxt   = LOAD_PTR;
          end
          CMD_RUN:  w_state_nxt = ST_RUN;
          CMD_DUMP: begin
            w_state_nxt = ST_DUMP;
            w_ptr_nxt   = '0;
          end
          default:  w_state_nxt = ST_IDLE;
        endcase
      end
      ST_LOAD: begin
        // in_ready is high throughout LOAD, so in_valid alone is the handshake.
        if (in_valid) begin
          w_we      = 1'b1;
          w_ptr_nxt = r_ptr + 1'b1;
          if (in_last) w_state_nxt = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (bus_oe == OE_WRITE) begin
          w_we    = 1'b1;
          w_waddr = bus_addr;
          w_wdata = bus_wdata;
        end
        w_err_set = oe_malformed(bus_oe);
        if (w_cmd == CMD_NONE) w_state_nxt = ST_IDLE;
      end
      ST_DUMP: begin
        if (out_ready) begin
          w_ptr_nxt = r_ptr + 1'b1;
          if (r_ptr == TOP_ADDR) w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_ptr     <= '0;
      r_bus_err <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_ptr     <= w_ptr_nxt;
      if (w_err_set) r_bus_err <= 1'b1;
    end
  end

  // Outputs decode straight from the registered state so reset clears them at once.
  assign cpu_ena   = (r_state == ST_RUN);
  assign in_ready  = (r_state == ST_LOAD);
  assign out_valid = (r_state == ST_DUMP);
  assign out_data  = w_dump_rd;
  assign bus_rdata = cpu_ena ? w_bus_rd : 8'h00;
  assign bus_err   = r_bus_err;
  assign state_o   = r_state;

endmodule

// File: tb/tb_bf_mem_responder.sv
// Self-checking bench for bf_mem_responder: a reference byte array tracks every
// load and bus write, and dumps are checked against a queue of expected bytes.
module tb_bf_mem_responder;
  import bf_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] bus_addr, bus_wdata, bus_oe, bus_rdata;
  logic       cpu_ena;
  logic [1:0] host_cmd;
  logic       in_valid, in_ready, in_last;
  logic [7:0] in_data;
  logic       out_valid, out_ready;
  logic [7:0] out_data;
  logic       bus_err;
  logic [1:0] state_o;

  logic [7:0] model_mem [256];
  logic [7:0] exp_q [$];
  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  bf_mem_responder #(.ADDR_W(8), .LOAD_BASE(0)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus_addr  (bus_addr),
    .bus_wdata (bus_wdata),
    .bus_oe    (bus_oe),
    .bus_rdata (bus_rdata),
    .cpu_ena   (cpu_ena),
    .host_cmd  (host_cmd),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .bus_err   (bus_err),
    .state_o   (state_o)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; host_cmd = CMD_NONE; in_valid = 0; in_last = 0; in_data = 0;
    out_ready = 0; bus_addr = 0; bus_wdata = 0; bus_oe = OE_READ;
    #3;
    n_tests++; if (state_o !== 2'b00) begin n_fail++; $display("FAIL reset_state got %h want 00", state_o); end
    n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready got %b want 0", in_ready); end
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    n_tests++; if (cpu_ena !== 1'b0) begin n_fail++; $display("FAIL reset_cpu_ena got %b want 0", cpu_ena); end
    n_tests++; if (bus_err !== 1'b0) begin n_fail++; $display("FAIL reset_bus_err got %b want 0", bus_err); end
    n_tests++; if (bus_rdata !== 8'h00) begin n_fail++; $display("FAIL reset_bus_rdata got %h want 00", bus_rdata); end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  // Loads a byte sequence from address 0, marking the final byte with in_last.
  task automatic do_load(input logic [7:0] bytes [$], input string tag);
    logic [7:0] m_ptr = 8'h00;
    host_cmd = CMD_LOAD;
    tick();
    host_cmd = CMD_NONE;
    n_tests++; if (state_o !== 2'b01) begin n_fail++; $display("FAIL %s_enter got %h want 01", tag, state_o); end
    for (int i = 0; i < bytes.size(); i++) begin
      in_valid = 1'b1;
      in_data  = bytes[i];
      in_last  = (i == bytes.size() - 1);
      #1;
      n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL %s_in_ready byte %0d got %b want 1", tag, i, in_ready); end
      tick();
      model_mem[m_ptr] = bytes[i];
      m_ptr++;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    #1;
    n_tests++; if (state_o !== 2'b00) begin n_fail++; $display("FAIL %s_exit_state got %h want 00", tag, state_o); end
    n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL %s_exit_in_ready got %b want 0", tag, in_ready); end
  endtask

  // Dumps the full array; with toggle set, out_ready alternates and stalled
  // cycles must hold out_data steady.
  task automatic do_dump(input bit toggle, input string tag);
    logic [7:0] held = 8'h00;
    logic [7:0] exp_b;
    bit stalled = 1'b0;
    int cyc = 0;
    int idx = 0;
    exp_q.delete();
    for (int a = 0; a < 256; a++) exp_q.push_back(model_mem[a]);
    host_cmd = CMD_DUMP;
    tick();
    host_cmd  = CMD_NONE;
    out_ready = toggle ? 1'b0 : 1'b1;
    #1;
    n_tests++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL %s_out_valid got %b want 1", tag, out_valid); end
    while (exp_q.size() > 0 && cyc < 2000) begin
      if (stalled) begin
        n_tests++;
        if (out_data !== held) begin n_fail++; $display("FAIL %s_stall_stable idx %0d got %h want %h", tag, idx, out_data, held); end
      end
      if (out_valid && out_ready) begin
        exp_b = exp_q.pop_front();
        n_tests++;
        if (out_data !== exp_b) begin n_fail++; $display("FAIL %s_data idx %0d got %h want %h", tag, idx, out_data, exp_b); end
        idx++;
        stalled = 1'b0;
      end else begin
        held    = out_data;
        stalled = out_valid;
      end
      tick();
      cyc++;
      if (toggle) out_ready = ~out_ready;
      #1;
    end
    n_tests++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL %s_timeout got %0d bytes left want 0", tag, exp_q.size()); end
    out_ready = 1'b0;
    n_tests++; if (state_o !== 2'b00) begin n_fail++; $display("FAIL %s_exit_state got %h want 00", tag, state_o); end
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL %s_exit_out_valid got %b want 0", tag, out_valid); end
  endtask

  task automatic test_wrap_load();
    logic [7:0] q [$];
    for (int i = 0; i < 260; i++) q.push_back(8'((i * 37 + 11) & 255));
    do_load(q, "wrap_load");
    for (int k = 0; k < 4; k++) begin
      n_tests++;
      if (model_mem[k] !== q[256 + k]) begin n_fail++; $display("FAIL wrap_model addr %0d got %h want %h", k, model_mem[k], q[256 + k]); end
    end
    do_dump(1'b0, "wrap_dump");
  endtask

  task automatic test_load3();
    logic [7:0] q [$];
    q = '{8'h2B, 8'h3E, 8'h2E};
    do_load(q, "load3");
  endtask

  task automatic test_run();
    logic [7:0] prog [3];
    prog = '{8'h2B, 8'h3E, 8'h2E};
    host_cmd = CMD_RUN;
    tick();
    n_tests++; if (state_o !== 2'b10) begin n_fail++; $display("FAIL run_state got %h want 10", state_o); end
    n_tests++; if (cpu_ena !== 1'b1) begin n_fail++; $display("FAIL run_cpu_ena got %b want 1", cpu_ena); end
    for (int a = 0; a < 3; a++) begin
      bus_addr = 8'(a);
      bus_oe   = OE_READ;
      #1;
      n_tests++;
      if (bus_rdata !== prog[a]) begin n_fail++; $display("FAIL run_read addr %0d got %h want %h", a, bus_rdata, prog[a]); end
    end
    bus_addr = 8'h05; bus_oe = OE_WRITE; bus_wdata = 8'hA5;
    tick();
    model_mem[5] = 8'hA5;
    bus_oe = OE_READ;
    #1;
    n_tests++; if (bus_rdata !== 8'hA5) begin n_fail++; $display("FAIL run_write_readback got %h want a5", bus_rdata); end
    n_tests++; if (bus_err !== 1'b0) begin n_fail++; $display("FAIL run_err_clean got %b want 0", bus_err); end
    bus_oe = 8'h0F; bus_wdata = 8'h3C;
    tick();
    bus_oe = OE_READ;
    #1;
    n_tests++; if (bus_err !== 1'b1) begin n_fail++; $display("FAIL run_err_set got %b want 1", bus_err); end
    n_tests++; if (bus_rdata !== 8'hA5) begin n_fail++; $display("FAIL run_err_nowrite got %h want a5", bus_rdata); end
    host_cmd = CMD_NONE;
    #1;
    n_tests++; if (cpu_ena !== 1'b1) begin n_fail++; $display("FAIL run_exit_early got %b want 1", cpu_ena); end
    tick();
    n_tests++; if (state_o !== 2'b00) begin n_fail++; $display("FAIL run_exit_state got %h want 00", state_o); end
    n_tests++; if (cpu_ena !== 1'b0) begin n_fail++; $display("FAIL run_exit_cpu_ena got %b want 0", cpu_ena); end
    n_tests++; if (bus_rdata !== 8'h00) begin n_fail++; $display("FAIL idle_bus_rdata got %h want 00", bus_rdata); end
    n_tests++; if (bus_err !== 1'b1) begin n_fail++; $display("FAIL idle_err_sticky got %b want 1", bus_err); end
    // A bus write attempted in IDLE must not reach the array.
    bus_addr = 8'h06; bus_oe = OE_WRITE; bus_wdata = 8'hE7;
    tick();
    bus_oe = OE_READ;
  endtask

  task automatic test_reset_mid_load();
    host_cmd = CMD_LOAD;
    tick();
    host_cmd = CMD_NONE;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1;
      in_data  = 8'hC1 + 8'(i);
      in_last  = 1'b0;
      tick();
      model_mem[i] = 8'hC1 + 8'(i);
    end
    in_valid = 1'b0;
    #1;
    rst_n = 1'b0;
    #1;
    n_tests++; if (state_o !== 2'b00) begin n_fail++; $display("FAIL midreset_state got %h want 00", state_o); end
    n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL midreset_in_ready got %b want 0", in_ready); end
    n_tests++; if (bus_err !== 1'b0) begin n_fail++; $display("FAIL midreset_bus_err got %b want 0", bus_err); end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    do_dump(1'b0, "midreset_dump");
  endtask

  initial begin
    test_reset();
    test_wrap_load();
    test_load3();
    test_run();
    do_dump(1'b1, "toggle_dump");
    test_reset_mid_load();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog expired");
  end

endmodule
